out_sched: RTL

OUT_SCHED -- requirements
Module: out_sched

---
 rtl/out_sched.sv | 105 ++++++++++
 1 files changed

// File: rtl/out_sched.sv
// ============================================================================
//  Module   : out_sched
//  Purpose  : Round-robin scheduler that grants three requesters a shared
//             output register, then holds it for HOLD cycles per grant.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module out_sched #(
    parameter int HOLD = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [15:0] din0,
    input  logic [15:0] din1,
    input  logic [15:0] din2,
    output logic [15:0] out,
    output logic [2:0]  grant,
    output logic        busy,
    output logic [7:0]  xfer_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] C_HOLD_M1 = 4'(HOLD - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [1:0]  r_last;
    logic [15:0] r_out;
    logic [2:0]  r_grant;
    logic [7:0]  r_xfer;

    logic [1:0]  w_sel;
    logic [15:0] w_din;

    // Search starts one past the previous winner and wraps 0->1->2->0.
    always_comb begin
        case (r_last)
            2'd0:    w_sel = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    w_sel = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: w_sel = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        case (w_sel)
            2'd0:    w_din = din0;
            2'd1:    w_din = din1;
            default: w_din = din2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_out   <= 16'h0000;
            r_grant <= 3'b000;
            r_xfer  <= 8'h00;
            r_cnt   <= 4'd0;
            r_last  <= 2'd2;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req != 3'b000) begin
                        r_out   <= w_din;
                        r_grant <= 3'b001 << w_sel;
                        r_last  <= w_sel;
                        r_xfer  <= r_xfer + 8'd1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_grant <= 3'b000;
                    r_cnt   <= C_HOLD_M1;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_grant <= 3'b000;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out      = r_out;
    assign grant    = r_grant;
    assign xfer_cnt = r_xfer;
    assign busy     = (r_state != S_IDLE);

endmodule

`default_nettype wire
